// File: rtl/ofm_drain.sv
// Output drain below a systolic-array column: requantizes accumulated partial
// sums (round-half-up, saturate) into a small FIFO with a valid/ready output.
module ofm_drain #(
  parameter int OWIDTH  = 24,
  parameter int QWIDTH  = 8,
  parameter int DEPTH   = 4,
  parameter int SHIFT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vld,
  input  logic signed [OWIDTH-1:0]  ofm,
  input  logic [SHIFT_W-1:0]        shift,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic signed [QWIDTH-1:0]  out_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      sat_flag,
  output logic                      drop_flag,
  input  logic                      flag_clr
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int QMAX_I = 2 ** (QWIDTH - 1) - 1;
  localparam int QMIN_I = -(2 ** (QWIDTH - 1));

  localparam logic signed [OWIDTH:0]   Q_MAX  = $signed((OWIDTH + 1)'(QMAX_I));
  localparam logic signed [OWIDTH:0]   Q_MIN  = $signed((OWIDTH + 1)'(QMIN_I));
  localparam logic [SHIFT_W-1:0]       SH_MAX = SHIFT_W'(OWIDTH - 1);
  localparam logic [CW-1:0]            FULL_C = CW'(DEPTH);

  // Stage 1 state
  logic                     s1_vld;
  logic signed [OWIDTH-1:0] s1_ofm;
  logic [SHIFT_W-1:0]       s1_sh;
  logic [SHIFT_W-1:0]       sh_eff;

  // Stage 2 state
  logic                     s2_vld;
  logic signed [QWIDTH-1:0] s2_data;

  // Requantization datapath
  logic signed [OWIDTH:0]   ext;
  logic signed [OWIDTH:0]   rnd;
  logic signed [OWIDTH:0]   sum;
  logic signed [OWIDTH:0]   rq;
  logic signed [QWIDTH-1:0] sat_val;
  logic                     sat_evt;

  // FIFO state and control
  logic signed [QWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [AW-1:0]            rd_nxt;
  logic signed [QWIDTH-1:0] head_nxt;
  logic                     full;
  logic                     pop;
  logic                     push;
  logic                     drop;

  // Shift amounts past the sign bit carry no information; clamp them.
  assign sh_eff = (int'(shift) > OWIDTH - 1) ? SH_MAX : shift;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rnd = '0;
    if (s1_sh != '0) rnd = $signed({{OWIDTH{1'b0}}, 1'b1} << (s1_sh - 1'b1));
    ext = {s1_ofm[OWIDTH-1], s1_ofm};
    sum = ext + rnd;
    rq  = sum >>> s1_sh;
  end

  always_comb begin
    sat_val = rq[QWIDTH-1:0];
    sat_evt = 1'b0;
    if (rq > Q_MAX) begin
      sat_val = Q_MAX[QWIDTH-1:0];
      sat_evt = s1_vld;
    end else if (rq < Q_MIN) begin
      sat_val = Q_MIN[QWIDTH-1:0];
      sat_evt = s1_vld;
    end
  end

  assign full    = (count == FULL_C);
  assign out_vld = (count != '0);
  assign pop     = out_vld && out_rdy;
  assign push    = s2_vld && (!full || pop);
  assign drop    = s2_vld && full && !pop;
  assign rd_nxt  = pop ? rd_ptr + 1'b1 : rd_ptr;

  // Next head bypasses the write when the new tail is also the new head.
  assign head_nxt = (push && (wr_ptr == rd_nxt)) ? s2_data : mem[rd_nxt];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_ofm    <= '0;
      s1_sh     <= '0;
      s2_vld    <= 1'b0;
      s2_data   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_ofm <= ofm;
        s1_sh  <= sh_eff;
      end

      s2_vld <= s1_vld;
      if (s1_vld) s2_data <= sat_val;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= rd_nxt;
      out_data <= head_nxt;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A set event in the same cycle as flag_clr wins.
      if (sat_evt)       sat_flag <= 1'b1;
      else if (flag_clr) sat_flag <= 1'b0;

      if (drop)          drop_flag <= 1'b1;
      else if (flag_clr) drop_flag <= 1'b0;
    end
  end

  // NOTE: FIFO storage is not reset; count/pointers gate every read, so contents never leak.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s2_data;
  end

endmodule

// File: doc/ofm_drain.md
# ofm_drain

Output drain stage that sits directly below the bottom-row border PE of each systolic-array column. It captures the column's OWIDTH-bit accumulated partial sums as they leave the array and requantizes each one to QWIDTH bits with round-half-up and saturation. Results are buffered in a small FIFO and presented downstream on a valid/ready interface. The array cannot stall, so when the FIFO is full, incoming results are dropped and flagged rather than back-pressured.

## Interface
- OWIDTH, 24, width of incoming accumulated ofm (signed)
- QWIDTH, 8, width of requantized output (signed)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- SHIFT_W, 5, width of the requantization shift amount
- clk  in  1  clock, all state rising-edge
- rst  in  1  reset, asynchronous, active-high
- in_vld  in  1  ofm is a finished result this cycle (driven from the column's final en_o/clr_o sequencing)
- ofm  in  OWIDTH  signed accumulated result from the bottom PE's ofm_d
- shift  in  SHIFT_W  right-shift amount; sampled together with ofm when in_vld=1
- out_vld  out  1  out_data holds a valid entry
- out_rdy  in  1  downstream accepts; a pop occurs when out_vld & out_rdy
- out_data  out  QWIDTH  signed requantized value, head of FIFO
- count  out  $clog2(DEPTH)+1  committed FIFO occupancy
- sat_flag  out  1  sticky: some result saturated
- drop_flag  out  1  sticky: some result was dropped on full
- flag_clr  in  1  synchronous clear of both sticky flags

## Operation
- Stage 1 (S1): on in_vld=1, register ofm, an effective shift value and a valid bit. The effective shift is min(shift, OWIDTH-1). On in_vld=0, the S1 valid bit becomes 0.
- S1 arithmetic is done in OWIDTH+1 bits: r = (ofm + (sh>0 ? 1<<(sh-1) : 0)) >>> sh. This is an arithmetic shift, rounding half toward +inf.
- Stage 2 (S2): saturate r to [-2^(QWIDTH-1), 2^(QWIDTH-1)-1].
  - If clamping occurs, sat_flag is set.
  - S2 registers the saturated value and its valid bit.
- Commit: when S2 valid=1, the entry is written to the FIFO tail unless the FIFO is full with no pop in the same cycle.
  - In that case the entry is discarded and drop_flag is set.
  - The FIFO contents are not disturbed by a drop.
- FIFO: circular buffer with wrapping read and write pointers.
  - out_data is the registered head entry. out_vld = (count != 0).
- Simultaneous push and pop: both take effect and count is unchanged. This also applies when the FIFO is full, so no drop occurs.
- Pop on empty is impossible, because out_vld=0 makes the handshake false.
- Flag priority: flag_clr=1 clears the flags in that cycle. If a set event occurs in the same cycle, set wins and the flag stays 1.
- Reset (asserted at any time, including mid-stream): S1/S2 valid=0, pointers=0, count=0, out_vld=0, out_data=0, sat_flag=0, drop_flag=0. Results in flight are lost.

## Timing
- Pipeline latency is 2 clocks from a sampled in_vld to the FIFO write.
  - A result sampled at edge t is committed at edge t+2.
  - out_vld rises after edge t+2 if the FIFO was empty.
- Throughput is one result per cycle in and one per cycle out.
- out_data and out_vld change only after a clock edge or on reset. They do not depend combinationally on out_rdy.
- count updates at the commit or pop edge. The full condition is count==DEPTH.
- sat_flag is set at the S2 edge of the offending result. drop_flag is set at the commit edge of the discarded result.

## Test plan
- Rounding: shift=4; ofm=100, -100, 8, -8 pushed back-to-back with out_rdy=1 -> out_data sequence 6, -6, 1, 0. The first out_vld appears 2 cycles after the first sample. No flags are set.
- Saturation: shift=4, ofm=5000 -> 127 and sat_flag=1. Then shift=0, ofm=-129 -> -128. Then flag_clr=1 -> sat_flag=0.
- Shift clamp: shift=31, OWIDTH=24, ofm=-(2^23) -> -1. With ofm=2^22 -> 1 (round-half-up at bit 22). shift=0, ofm=127 -> 127 unchanged.
- Full/drop: out_rdy=0; push 6 consecutive results with values 1..6 -> count=4 and drop_flag=1. Then out_rdy=1 -> pops 1, 2, 3, 4 in order, then out_vld=0.
- Full with simultaneous pop: fill to 4, then hold out_rdy=1 while pushing continuously -> count stays 4, drop_flag stays 0, no value lost or reordered. Pointers wrap correctly over ≥3 full laps.
- Reset mid-operation: assert rst while 2 entries are in S1/S2 and 3 are in the FIFO -> out_vld=0, count=0, flags=0 immediately. After deassert, a new push appears 2 cycles later with no stale data.
